xfm_quant: RTL and testbench

XFM_QUANT -- requirements
Module: xfm_quant

---
 rtl/xfm_pkg.sv | 36 +++
 rtl/xfm_quant_c.sv | 52 +++++
 rtl/xfm_quant.sv | 114 +++++++++++
 tb/tb_xfm_quant.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xfm_pkg.sv
// Shared constants, FSM encoding and scale lookup for the
// forward-transform quantizer.
package xfm_pkg;

    localparam int COEFF_SIZE = 9;
    localparam int RES_SIZE   = 16;
    localparam int QP_MAX     = 71;
    localparam int NCOEF      = 16;
    localparam int NCOMP      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q0,
        S_Q1,
        S_Q2,
        S_OUT
    } state_e;

    function automatic logic [11:0] scale_of(input logic [2:0] qp_mod);
        logic [11:0] s;
        s = 12'd2048;
        unique case (qp_mod)
            3'd0: s = 12'd2048;
            3'd1: s = 12'd1825;
            3'd2: s = 12'd1626;
            3'd3: s = 12'd1448;
            3'd4: s = 12'd1290;
            3'd5: s = 12'd1149;
            3'd6: s = 12'd1024;
            3'd7: s = 12'd912;
            default: s = 12'd2048;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/xfm_quant_c.sv
// Sixteen-lane combinational quantizer for one colour component,
// with clipping to the output coefficient range and a nonzero flag.
module xfm_quant_c #(
    parameter int COEFF_SIZE = xfm_pkg::COEFF_SIZE,
    parameter int RES_SIZE   = xfm_pkg::RES_SIZE
) (
    input  logic [16*RES_SIZE-1:0]   res_i,
    input  logic [3:0]               qp_div_i,
    input  logic [2:0]               qp_mod_i,
    output logic [16*COEFF_SIZE-1:0] coeff_o,
    output logic                     nz_o
);
    import xfm_pkg::*;

    // Wide enough for |x| * 2048 + 2^17 without overflow.
    localparam int PW = RES_SIZE + 14;
    localparam logic [PW-1:0] MAXP = PW'((1 << (COEFF_SIZE - 1)) - 1);
    localparam logic [PW-1:0] MAXN = PW'(1 << (COEFF_SIZE - 1));

    logic [11:0]   scale;
    logic [4:0]    sh;
    logic [PW-1:0] off;
    logic [15:0]   nz;

    assign scale = scale_of(qp_mod_i);
    assign sh    = 5'd11 + {1'b0, qp_div_i};
    assign off   = PW'(1) << (sh - 5'd2);
    assign nz_o  = |nz;

    for (genvar k = 0; k < 16; k++) begin : g_lane
        logic [RES_SIZE-1:0] xb;
        logic [RES_SIZE-1:0] mag;
        logic [PW-1:0]       prod;
        logic [PW-1:0]       q;
        logic [PW-1:0]       lim;
        logic [PW-1:0]       qc;
        logic [COEFF_SIZE-1:0] v;

        assign xb   = res_i[k*RES_SIZE +: RES_SIZE];
        assign mag  = xb[RES_SIZE-1] ? (~xb + 1'b1) : xb;
        assign prod = PW'(mag) * PW'(scale);
        assign q    = (prod + off) >> sh;
        assign lim  = xb[RES_SIZE-1] ? MAXN : MAXP;
        assign qc   = (q > lim) ? lim : q;
        assign v    = xb[RES_SIZE-1] ? COEFF_SIZE'(PW'(0) - qc)
                                     : COEFF_SIZE'(qc);

        assign coeff_o[k*COEFF_SIZE +: COEFF_SIZE] = v;
        assign nz[k] = |v;
    end

endmodule

// File: rtl/xfm_quant.sv
// Block quantizer: accepts three 16-coefficient components and
// quantizes one component per cycle through a shared lane array.
module xfm_quant #(
    parameter int COEFF_SIZE = xfm_pkg::COEFF_SIZE,
    parameter int RES_SIZE   = xfm_pkg::RES_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 m_qp,
    input  logic [3*16*RES_SIZE-1:0]   xfm_res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3*16*COEFF_SIZE-1:0] xfm_coeff,
    output logic [2:0]                 cbf
);
    import xfm_pkg::*;

    localparam int RW = 16 * RES_SIZE;
    localparam int CW = 16 * COEFF_SIZE;

    state_e                       state_q;
    logic [3*RW-1:0]              res_q;
    logic [6:0]                   qp_q;
    logic [3*CW-1:0]              coeff_q;
    logic [2:0]                   cbf_q;
    logic                         in_ready_q;
    logic                         out_valid_q;

    logic [7:0]                   qp_clamp;
    logic [RW-1:0]                lane_res;
    logic [CW-1:0]                lane_coeff;
    logic                         lane_nz;

    assign qp_clamp = (m_qp > 8'(QP_MAX)) ? 8'(QP_MAX) : m_qp;

    always_comb begin
        lane_res = res_q[0 +: RW];
        unique case (state_q)
            S_Q1:    lane_res = res_q[RW +: RW];
            S_Q2:    lane_res = res_q[2*RW +: RW];
            default: lane_res = res_q[0 +: RW];
        endcase
    end

    xfm_quant_c #(
        .COEFF_SIZE(COEFF_SIZE),
        .RES_SIZE  (RES_SIZE)
    ) u_quant (
        .res_i    (lane_res),
        .qp_div_i (qp_q[6:3]),
        .qp_mod_i (qp_q[2:0]),
        .coeff_o  (lane_coeff),
        .nz_o     (lane_nz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            qp_q        <= '0;
            coeff_q     <= '0;
            cbf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        res_q      <= xfm_res;
                        qp_q       <= qp_clamp[6:0];
                        in_ready_q <= 1'b0;
                        state_q    <= S_Q0;
                    end
                end
                S_Q0: begin
                    coeff_q[0 +: CW] <= lane_coeff;
                    cbf_q[0]         <= lane_nz;
                    state_q          <= S_Q1;
                end
                S_Q1: begin
                    coeff_q[CW +: CW] <= lane_coeff;
                    cbf_q[1]          <= lane_nz;
                    state_q           <= S_Q2;
                end
                S_Q2: begin
                    coeff_q[2*CW +: CW] <= lane_coeff;
                    cbf_q[2]            <= lane_nz;
                    out_valid_q         <= 1'b1;
                    state_q             <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign xfm_coeff = coeff_q;
    assign cbf       = cbf_q;

endmodule

// File: tb/tb_xfm_quant.sv
// Directed vector bench for xfm_quant: table rows plus
// back-pressure and mid-block reset sequences.
module tb_xfm_quant;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   m_qp;
    logic [767:0] xfm_res;
    logic         out_valid;
    logic         out_ready;
    logic [431:0] xfm_coeff;
    logic [2:0]   cbf;

    int checks;
    int failures;

    xfm_quant dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_qp      (m_qp),
        .xfm_res   (xfm_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfm_coeff (xfm_coeff),
        .cbf       (cbf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  qp;
        logic [15:0] x0, x1, x2;
        logic [8:0]  e0, e1, e2;
        logic [2:0]  ecbf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_comp(input string nm, input int c,
                            input logic [8:0] e);
        logic [143:0] got;
        logic [143:0] exp;
        got = xfm_coeff[c*144 +: 144];
        exp = {16{e}};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s comp%0d: got %h expected %h", nm, c, got, exp);
        end
    endtask

    task automatic set_res(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c);
        for (int k = 0; k < 16; k++) begin
            xfm_res[(0*16+k)*16 +: 16] = a;
            xfm_res[(1*16+k)*16 +: 16] = b;
            xfm_res[(2*16+k)*16 +: 16] = c;
        end
    endtask

    // Offer a block, return cycles from acceptance to out_valid.
    task automatic send(input logic [7:0] qp, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c,
                        output int lat);
        @(negedge clk);
        m_qp = qp;
        set_res(a, b, c);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m_qp = 8'($urandom);
        for (int i = 0; i < 48; i++) xfm_res[i*16 +: 16] = 16'($urandom);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_row(input int r);
        int lat;
        string nm;
        nm = $sformatf("row%0d", r);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        send(tbl[r].qp, tbl[r].x0, tbl[r].x1, tbl[r].x2, lat);
        chk({nm, " latency"}, 32'(lat), 32'd4);
        chk_comp(nm, 0, tbl[r].e0);
        chk_comp(nm, 1, tbl[r].e1);
        chk_comp(nm, 2, tbl[r].e2);
        chk({nm, " cbf"}, 32'(cbf), 32'(tbl[r].ecbf));
        @(posedge clk);
        #1;
        chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [431:0] snap_c;
        logic [2:0]   snap_b;
        int           lat;
        logic         seen;

        checks   = 0;
        failures = 0;

        tbl[0] = '{8'd0,   16'd100,   16'd100,    16'd100,
                   9'd100, 9'd100,    9'd100,     3'b111};
        tbl[1] = '{8'd8,   16'd100,   -16'sd100,  16'd0,
                   9'd50,  9'h1CE,    9'd0,       3'b011};
        tbl[2] = '{8'd16,  16'd1,     16'd100,    -16'sd1,
                   9'd0,   9'd25,     9'd0,       3'b010};
        tbl[3] = '{8'd71,  16'd32767, -16'sd32768, 16'd1000,
                   9'd57,  9'h1C7,    9'd1,       3'b111};
        tbl[4] = '{8'd200, 16'd32767, -16'sd32768, 16'd1000,
                   9'd57,  9'h1C7,    9'd1,       3'b111};
        tbl[5] = '{8'd0,   16'd32767, -16'sd32768, -16'sd257,
                   9'h0FF, 9'h100,    9'h100,     3'b111};
        tbl[6] = '{8'd5,   16'd100,   -16'sd7,    16'd1,
                   9'd56,  9'h1FC,    9'd0,       3'b011};
        tbl[7] = '{8'd3,   -16'sd1,   16'd2,      -16'sd2,
                   9'd0,   9'd1,      9'h1FF,     3'b110};
        tbl[8] = '{8'd42,  16'd1000,  -16'sd20000, 16'd20000,
                   9'd25,  9'h100,    9'h0FF,     3'b111};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m_qp      = '0;
        xfm_res   = '0;
        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset coeff", 32'(|xfm_coeff), 32'd0);
        chk("reset cbf", 32'(cbf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 9; r++) run_row(r);

        // Back-pressure: hold in OUT while a competing block is offered.
        out_ready = 1'b0;
        send(8'd0, 16'd100, 16'd100, 16'd100, lat);
        chk("bp latency", 32'(lat), 32'd4);
        snap_c = xfm_coeff;
        snap_b = cbf;
        chk_comp("bp", 0, 9'd100);
        m_qp = 8'd8;
        set_res(-16'sd100, -16'sd100, -16'sd100);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d", i),
                32'({out_valid, in_ready, xfm_coeff == snap_c,
                     cbf == snap_b}),
                32'b1011);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release valid", 32'(out_valid), 32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp ignored block", 32'(seen), 32'd0);
        run_row(1);

        // Reset while component 1 is being quantized.
        @(negedge clk);
        m_qp = 8'd0;
        set_res(16'd100, 16'd100, 16'd100);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre-rst comp0", 32'(xfm_coeff[8:0]), 32'd100);
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst coeff", 32'(|xfm_coeff), 32'd0);
        chk("rst cbf", 32'(cbf), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_row(8);
        run_row(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
